// File: rtl/pattern_tx_serializer.sv
// rtl/pattern_tx_serializer.sv - serial pattern transmitter, MSB first, repeated N times
// Optional inter-repetition idle gap enabled by defining GAP_INSERT_EN.
module pattern_tx_serializer #(
  parameter int PAT_W   = 4,
  parameter int CNT_W   = 4,
  parameter int GAP_LEN = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PAT_W-1:0] Pattern_in,
  input  logic [CNT_W-1:0] Repeat,
  output logic             Dout,
  output logic             Valid,
  output logic             Busy,
  output logic             Done
);

  localparam int BIT_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

`ifdef GAP_INSERT_EN
  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef GAP_INSERT_EN
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  // shreg holds the bits still to be sent; its MSB is the next bit onto the line
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    rem_d   = rem_q;
    dout_d  = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef GAP_INSERT_EN
    gap_d   = gap_q;
`endif

    case (state_q)
      IDLE: begin
        if (Start) begin
          if (Repeat != '0) begin
            state_d = SEND;
            pat_d   = Pattern_in;
            shreg_d = {Pattern_in[PAT_W-2:0], 1'b0};
            bit_d   = '0;
            rem_d   = Repeat;
            dout_d  = Pattern_in[PAT_W-1];
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            busy_d  = 1'b1;
            done_d  = 1'b1;
          end
        end
      end

      SEND: begin
        busy_d = 1'b1;
        if (bit_q != LAST_BIT) begin
          dout_d  = shreg_q[PAT_W-1];
          valid_d = 1'b1;
          shreg_d = {shreg_q[PAT_W-2:0], 1'b0};
          bit_d   = bit_q + 1'b1;
        end else begin
          bit_d = '0;
          rem_d = rem_q - 1'b1;
          if (rem_q != CNT_W'(1)) begin
`ifdef GAP_INSERT_EN
            state_d = GAP;
            gap_d   = '0;
`else
            dout_d  = pat_q[PAT_W-1];
            valid_d = 1'b1;
            shreg_d = {pat_q[PAT_W-2:0], 1'b0};
`endif
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

`ifdef GAP_INSERT_EN
      GAP: begin
        busy_d = 1'b1;
        if (gap_q == LAST_GAP) begin
          state_d = SEND;
          dout_d  = pat_q[PAT_W-1];
          valid_d = 1'b1;
          shreg_d = {pat_q[PAT_W-2:0], 1'b0};
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      shreg_q <= '0;
      bit_q   <= '0;
      rem_q   <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef GAP_INSERT_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      rem_q   <= rem_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef GAP_INSERT_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign Dout  = dout_q;
  assign Valid = valid_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_pattern_tx_serializer.sv
// tb/tb_pattern_tx_serializer.sv - scoreboard bench for pattern_tx_serializer
module tb_pattern_tx_serializer;

  localparam int PAT_W   = 4;
  localparam int CNT_W   = 4;
  localparam int GAP_LEN = 2;

  logic             Clock = 1'b0;
  logic             Reset = 1'b0;
  logic             Start = 1'b0;
  logic [PAT_W-1:0] Pattern_in = '0;
  logic [CNT_W-1:0] Repeat = '0;
  logic             Dout;
  logic             Valid;
  logic             Busy;
  logic             Done;

  int checks    = 0;
  int failures  = 0;
  int valid_cnt = 0;
  bit exp_q[$];

  always #5 Clock = ~Clock;

  pattern_tx_serializer #(
    .PAT_W  (PAT_W),
    .CNT_W  (CNT_W),
    .GAP_LEN(GAP_LEN)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .Pattern_in(Pattern_in),
    .Repeat    (Repeat),
    .Dout      (Dout),
    .Valid     (Valid),
    .Busy      (Busy),
    .Done      (Done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input int r);
    if (r == 0) return 1;
`ifdef GAP_INSERT_EN
    return PAT_W * r + GAP_LEN * (r - 1) + 1;
`else
    return PAT_W * r + 1;
`endif
  endfunction

  // Scoreboard: every Valid bit is matched against the next queued pattern bit
  always @(negedge Clock) begin : monitor
    bit e;
    if (Reset) begin
      if (Valid === 1'b1) begin
        valid_cnt++;
        check("bit_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("dout_bit", 32'(Dout), 32'(e));
        end
      end else begin
        check("dout_idle_zero", 32'(Dout), 32'd0);
      end
    end
  end

  task automatic push_job(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rep);
    for (int r = 0; r < int'(rep); r++)
      for (int b = PAT_W - 1; b >= 0; b--)
        exp_q.push_back(pat[b]);
  endtask

  // Called at a negedge; returns at a negedge with the DUT back in IDLE
  task automatic run_job(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rep,
                         input bit disturb);
    int cyc;
    push_job(pat, rep);
    Start      = 1'b1;
    Pattern_in = pat;
    Repeat     = rep;
    valid_cnt  = 0;
    @(negedge Clock);
    Start = 1'b0;
    cyc   = 1;
    while (Done !== 1'b1 && cyc < 300) begin
      check("busy_during_job", 32'(Busy), 32'd1);
      if (disturb && cyc == 2) begin
        Start      = 1'b1;
        Pattern_in = 4'b0110;
        Repeat     = 4'd5;
      end else if (disturb && cyc == 3) begin
        Start = 1'b0;
      end
      @(negedge Clock);
      cyc++;
    end
    check("done_latency", 32'(cyc), 32'(exp_lat(int'(rep))));
    check("busy_at_done", 32'(Busy), 32'(rep == '0));
    check("valid_at_done", 32'(Valid), 32'd0);
    check("valid_count", 32'(valid_cnt), 32'(PAT_W * int'(rep)));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge Clock);
    check("done_one_cycle", 32'(Done), 32'd0);
    check("idle_busy", 32'(Busy), 32'd0);
    check("idle_valid", 32'(Valid), 32'd0);
  endtask

  initial begin
    // Power-up reset with Start already requested
    Start      = 1'b1;
    Pattern_in = 4'b1101;
    Repeat     = 4'd1;
    repeat (3) @(negedge Clock);
    check("rst_dout", 32'(Dout), 32'd0);
    check("rst_valid", 32'(Valid), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    Start = 1'b0;
    Reset = 1'b1;
    @(negedge Clock);

    run_job(4'b1101, 4'd1, 1'b0);
    run_job(4'b1101, 4'd3, 1'b0);
    run_job(4'b1111, 4'd0, 1'b0);
    run_job(4'b1101, 4'd2, 1'b1);

    // Abort mid-job with reset: outputs clear at once and no Done follows
    push_job(4'b1101, 4'd2);
    Start      = 1'b1;
    Pattern_in = 4'b1101;
    Repeat     = 4'd2;
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("abort_dout", 32'(Dout), 32'd0);
    check("abort_valid", 32'(Valid), 32'd0);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    exp_q.delete();
    @(negedge Clock);
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      check("post_abort_done", 32'(Done), 32'd0);
      check("post_abort_busy", 32'(Busy), 32'd0);
    end

    run_job(4'b1101, 4'd1, 1'b0);
    run_job(4'b1010, 4'd5, 1'b0);
    run_job(4'b0110, 4'd15, 1'b0);
    run_job(4'b1001, 4'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pattern_tx_serializer.md
Name: pattern_tx_serializer

Overview:
- Serial pattern transmitter. Drives a single-bit line with a programmable PAT_W-bit pattern, MSB first, repeated a programmable number of times.
- Counterpart to the team's Moore sequence detectors: generates the "1101"-style bit streams that those detectors consume.
- Sits between a control/test sequencer (Start/Done handshake) and any serial-bit consumer.

Parameters:
- PAT_W, 4, pattern width in bits (min 2).
- CNT_W, 4, width of the repeat-count input.
- GAP_LEN, 2, idle cycles between repetitions (used only with GAP_INSERT_EN; min 1).

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE.
- Pattern_in  input  PAT_W  pattern to send; latched on accepted Start.
- Repeat  input  CNT_W  number of pattern repetitions; latched on accepted Start.
- Dout  output  1  serial data, registered.
- Valid  output  1  high when Dout carries a pattern bit.
- Busy  output  1  high from accepted Start until Done.
- Done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE; Dout=0, Valid=0, Busy=0, Done=0; shift register and counters cleared. Takes effect immediately, including mid-frame. Transmission is aborted and no Done is issued.
- All outputs are registered; there is no combinational path from the inputs to the outputs.
- States: IDLE, SEND, GAP (only with GAP_INSERT_EN), DONE.
- IDLE:
  - Dout=0, Valid=0, Busy=0.
  - Start=1 at an edge with Repeat!=0: latch Pattern_in and Repeat; go to SEND. The same edge drives Dout=Pattern_in[PAT_W-1] with Valid=1 and Busy=1, so the first bit appears in the cycle right after the Start edge.
  - Start=1 with Repeat=0: go directly to DONE. Busy=1 and Done=1 for one cycle; no Valid bits.
- SEND:
  - One bit per cycle, MSB first, for PAT_W cycles.
  - Bit counter counts 0..PAT_W-1 and wraps to 0 at the end of each repetition.
  - Repeat remaining counter decrements once per completed repetition.
  - After the last bit of a repetition with remaining>0:
    - without gap: the next repetition's MSB follows in the very next cycle, with Valid staying high;
    - with gap: go to GAP.
  - After the last bit of the final repetition: go to DONE.
- GAP: Dout=0, Valid=0, Busy=1 for exactly GAP_LEN cycles, then SEND with the MSB.
- DONE: Dout=0, Valid=0, Busy=0, Done=1 for exactly one cycle, then IDLE.
- Start handling:
  - Ignored in SEND, GAP and DONE; not queued.
  - Minimum spacing between back-to-back jobs: Done cycle, then IDLE, then Start accepted.
- Pattern_in and Repeat changes after acceptance have no effect on the job in progress.
- Total Valid cycles per job = PAT_W × Repeat. Maximum Repeat = 2^CNT_W−1.
- Start-edge to Done-high latency:
  - without gap: PAT_W×Repeat+1 cycles;
  - with gap: PAT_W×Repeat+GAP_LEN×(Repeat−1)+1 cycles.

Optional Feature:
- Macro: GAP_INSERT_EN.
- Defined: the GAP state exists; GAP_LEN idle cycles (Dout=0, Valid=0) are inserted between consecutive repetitions. No gap before the first repetition or after the last.
- Undefined: no GAP state; repetitions are sent back-to-back with Valid continuously high for the whole job. GAP_LEN is unused.

Test Plan:
- Reset low during power-up, then Start=1, Pattern_in=4'b1101, Repeat=1 -> Dout=1,1,0,1 with Valid=1 for 4 cycles; Done pulse on the 5th cycle; Busy=1 for cycles 1–4.
- Pattern_in=4'b1101, Repeat=3, no macro -> Dout=110111011101 with Valid held for 12 cycles. Feeding Dout into the 1101 Moore detector yields 3 detections.
- Same job with GAP_INSERT_EN, GAP_LEN=2 -> Dout=1101 00 1101 00 1101 with Valid low during the 0 gaps; Done 17 cycles after the Start edge.
- Start=1 with Repeat=0 -> Done=1 the next cycle, Valid never high, back to IDLE after one cycle.
- Start pulsed again and Pattern_in changed to 4'b0110 mid-job (Repeat=2, 4'b1101) -> the job still sends 11011101 and the second Start is ignored. Reset asserted on bit 3 of a job -> all outputs 0 immediately, no Done; the next Start transmits normally.
